// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus controller: bus addresses, controller
// states and the baud divisor table (50 MHz clock, 16x oversampling).
package spart_pkg;

   localparam logic [1:0] ADDR_BUF  = 2'b00;
   localparam logic [1:0] ADDR_STAT = 2'b01;
   localparam logic [1:0] ADDR_DBL  = 2'b10;
   localparam logic [1:0] ADDR_DBH  = 2'b11;

   typedef enum logic [2:0] {
      ST_CFG_LO,
      ST_CFG_HI,
      ST_IDLE,
      ST_RX_RD,
      ST_TX_WR,
      ST_TX_GAP
   } ctrl_state_e;

   function automatic logic [15:0] baud_div(input logic [1:0] sel);
      logic [15:0] div;
      case (sel)
         2'b00:   div = 16'h028A;
         2'b01:   div = 16'h0145;
         2'b10:   div = 16'h00A2;
         default: div = 16'h0050;
      endcase
      return div;
   endfunction

endpackage

// File: rtl/spart_tx_fifo.sv
// Synchronous TX byte FIFO, TX_DEPTH entries (power of 2), head is
// presented combinationally; simultaneous push and pop keep the count.
module spart_tx_fifo #(
   parameter int TX_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic [7:0] din_i,
   input  logic       pop_i,
   output logic       full_o,
   output logic       empty_o,
   output logic [7:0] head_o
);

   localparam int AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [TX_DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [CW-1:0] cnt_q;
   logic          push_ok;
   logic          pop_ok;

   assign full_o  = (cnt_q == CW'(TX_DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + AW'(1);
         if (pop_ok)  rd_q <= rd_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage is data only; emptiness is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/spart_bus_ctrl.sv
// Bus master for one SPART: programs the baud divisor, then moves host TX
// bytes out and RX bytes in. Optional round-robin RX/TX arbitration: SPART_CTRL_RR_ARB_EN.
module spart_bus_ctrl
   import spart_pkg::*;
#(
   parameter int TX_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] br_cfg,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       cfg_done,
   output logic       iocs,
   output logic       iorw,
   output logic [1:0] ioaddr,
   input  logic       rda,
   input  logic       tbr,
   inout  wire  [7:0] databus
);

   ctrl_state_e state_q, state_d;
   logic [1:0]  br_cfg_q;
   logic        cfg_done_q;
   logic [7:0]  rx_data_q;
   logic        rx_valid_q;

   logic        fifo_full, fifo_empty;
   logic [7:0]  fifo_head;
   logic        cfg_chg, rx_elig, tx_elig, grant_rx, grant_tx;
   logic        cs, rw, drv;
   logic [1:0]  addr;
   logic [7:0]  dout;
   logic [15:0] div_lo, div_hi;

   spart_tx_fifo #(.TX_DEPTH(TX_DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (tx_valid),
      .din_i  (tx_data),
      .pop_i  (state_q == ST_TX_WR),
      .full_o (fifo_full),
      .empty_o(fifo_empty),
      .head_o (fifo_head)
   );

   // Low byte uses the live select (it is latched on this same cycle); high byte uses the latch.
   assign div_lo  = baud_div(br_cfg);
   assign div_hi  = baud_div(br_cfg_q);
   assign cfg_chg = (br_cfg != br_cfg_q);
   assign rx_elig = rda & (~rx_valid_q | rx_ready);
   assign tx_elig = ~fifo_empty & tbr;

`ifdef SPART_CTRL_RR_ARB_EN
   logic last_tx_q;

   assign grant_rx = (state_q == ST_IDLE) & ~cfg_chg & rx_elig & (~tx_elig | last_tx_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           last_tx_q <= 1'b1;
      else if (grant_rx) last_tx_q <= 1'b0;
      else if (grant_tx) last_tx_q <= 1'b1;
   end
`else
   assign grant_rx = (state_q == ST_IDLE) & ~cfg_chg & rx_elig;
`endif
   assign grant_tx = (state_q == ST_IDLE) & ~cfg_chg & tx_elig & ~grant_rx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_CFG_LO;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      cs      = 1'b0;
      rw      = 1'b1;
      addr    = ADDR_STAT;
      drv     = 1'b0;
      dout    = 8'h00;
      case (state_q)
         ST_CFG_LO: begin
            cs = 1'b1; rw = 1'b0; addr = ADDR_DBL; drv = 1'b1;
            dout    = div_lo[7:0];
            state_d = ST_CFG_HI;
         end
         ST_CFG_HI: begin
            cs = 1'b1; rw = 1'b0; addr = ADDR_DBH; drv = 1'b1;
            dout    = div_hi[15:8];
            state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (cfg_chg)       state_d = ST_CFG_LO;
            else if (grant_rx) state_d = ST_RX_RD;
            else if (grant_tx) state_d = ST_TX_WR;
         end
         ST_RX_RD: begin
            cs = 1'b1; addr = ADDR_BUF;
            state_d = ST_IDLE;
         end
         ST_TX_WR: begin
            cs = 1'b1; rw = 1'b0; addr = ADDR_BUF; drv = 1'b1;
            dout    = fifo_head;
            state_d = ST_TX_GAP;
         end
         ST_TX_GAP: state_d = ST_IDLE;
         default:   state_d = ST_CFG_LO;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_cfg_q   <= 2'b00;
         cfg_done_q <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
      end else begin
         if (state_q == ST_CFG_LO) br_cfg_q <= br_cfg;
         if (state_q == ST_CFG_HI)                cfg_done_q <= 1'b1;
         else if (state_q == ST_IDLE && cfg_chg) cfg_done_q <= 1'b0;
         if (state_q == ST_RX_RD) begin
            rx_data_q  <= databus;
            rx_valid_q <= 1'b1;
         end else if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

   // Bus is forced idle while rst is high so the SPART is released at once.
   assign iocs     = cs & ~rst;
   assign iorw     = rw | rst;
   assign ioaddr   = rst ? ADDR_STAT : addr;
   assign databus  = (drv & ~rst) ? dout : 8'hzz;
   assign tx_ready = ~fifo_full;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign cfg_done = cfg_done_q;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Directed bench for spart_bus_ctrl with a minimal SPART data-bus model.
module tb_spart_bus_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] br_cfg;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       cfg_done;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic       rda;
   logic       tbr;
   wire  [7:0] databus;
   logic [7:0] spart_byte;
   logic       spart_drv;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [1:0] cfg;
      logic [7:0] lo;
      logic [7:0] hi;
   } cfg_vec_t;

   cfg_vec_t cfg_tab [4];

   always #5 clk = ~clk;

   assign spart_drv = iocs && iorw && (ioaddr == 2'b00);
   assign databus   = spart_drv ? spart_byte : 8'hzz;

   spart_bus_ctrl #(.TX_DEPTH(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .br_cfg  (br_cfg),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .cfg_done(cfg_done),
      .iocs    (iocs),
      .iorw    (iorw),
      .ioaddr  (ioaddr),
      .rda     (rda),
      .tbr     (tbr),
      .databus (databus)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns "R" for a buffer read, "T" for a buffer write, "-" if none within limit cycles.
   task automatic next_grant(input int limit, output logic [7:0] g, output logic [7:0] d);
      g = "-";
      d = 8'h00;
      for (int i = 0; i < limit; i++) begin
         step();
         if (iocs && ioaddr == 2'b00) begin
            g = iorw ? "R" : "T";
            d = databus;
            return;
         end
      end
   endtask

   initial begin
      logic [7:0] g, d;
      int         acc;

      cfg_tab[0] = '{2'b11, 8'h50, 8'h00};
      cfg_tab[1] = '{2'b01, 8'h45, 8'h01};
      cfg_tab[2] = '{2'b10, 8'hA2, 8'h00};
      cfg_tab[3] = '{2'b00, 8'h8A, 8'h02};

      rst = 1'b1; br_cfg = 2'b00; tx_data = 8'h00; tx_valid = 1'b0;
      rx_ready = 1'b0; rda = 1'b0; tbr = 1'b0; spart_byte = 8'h00;
      step(); step();

      chk("rst_iocs", 16'(iocs), 16'h0);
      chk("rst_iorw", 16'(iorw), 16'h1);
      chk("rst_ioaddr", 16'(ioaddr), 16'h1);
      chk("rst_cfg_done", 16'(cfg_done), 16'h0);
      chk("rst_rx_valid", 16'(rx_valid), 16'h0);
      chk("rst_rx_data", 16'(rx_data), 16'h0);
      chk("rst_tx_ready", 16'(tx_ready), 16'h1);

      rst = 1'b0;
      #1;
      chk("cfglo_ioaddr", 16'(ioaddr), 16'h2);
      chk("cfglo_iorw", 16'(iorw), 16'h0);
      chk("cfglo_data", 16'(databus), 16'h8A);
      step();
      chk("cfghi_ioaddr", 16'(ioaddr), 16'h3);
      chk("cfghi_data", 16'(databus), 16'h02);
      chk("cfghi_done", 16'(cfg_done), 16'h0);
      step();
      chk("idle_done", 16'(cfg_done), 16'h1);
      chk("idle_iocs", 16'(iocs), 16'h0);

      for (int i = 0; i < 4; i++) begin
         br_cfg = cfg_tab[i].cfg;
         step();
         chk("tab_done_clr", 16'(cfg_done), 16'h0);
         chk("tab_lo_addr", 16'(ioaddr), 16'h2);
         chk("tab_lo_rw", 16'(iorw), 16'h0);
         chk("tab_lo_data", 16'(databus), 16'(cfg_tab[i].lo));
         step();
         chk("tab_hi_addr", 16'(ioaddr), 16'h3);
         chk("tab_hi_data", 16'(databus), 16'(cfg_tab[i].hi));
         step();
         chk("tab_done_set", 16'(cfg_done), 16'h1);
      end

      tx_data = 8'h61; tx_valid = 1'b1; tbr = 1'b1;
      step();
      tx_valid = 1'b0;
      step();
      chk("txwr_iocs", 16'(iocs), 16'h1);
      chk("txwr_iorw", 16'(iorw), 16'h0);
      chk("txwr_addr", 16'(ioaddr), 16'h0);
      chk("txwr_data", 16'(databus), 16'h61);
      step();
      chk("txgap_iocs", 16'(iocs), 16'h0);
      chk("txgap_ready", 16'(tx_ready), 16'h1);
      next_grant(6, g, d);
      chk("tx_empty_after_pop", 16'(g), 16'("-"));

      rda = 1'b1; spart_byte = 8'h50;
      step();
      chk("rxrd_iocs", 16'(iocs), 16'h1);
      chk("rxrd_iorw", 16'(iorw), 16'h1);
      chk("rxrd_addr", 16'(ioaddr), 16'h0);
      step();
      chk("rx_data_50", 16'(rx_data), 16'h50);
      chk("rx_valid_set", 16'(rx_valid), 16'h1);
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (iocs) acc++;
      end
      chk("rx_backpressure", 16'(acc), 16'h0);
      chk("rx_hold_data", 16'(rx_data), 16'h50);
      rx_ready = 1'b1; spart_byte = 8'h51;
      step();
      chk("rx2_rd", 16'(iocs && iorw), 16'h1);
      chk("rx2_valid_clr", 16'(rx_valid), 16'h0);
      rx_ready = 1'b0; rda = 1'b0;
      step();
      chk("rx2_data", 16'(rx_data), 16'h51);
      chk("rx2_valid", 16'(rx_valid), 16'h1);
      rx_ready = 1'b1;
      step();
      chk("rx_consumed", 16'(rx_valid), 16'h0);

      tbr = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tx_data = 8'hA0 + 8'(k); tx_valid = 1'b1;
         #1;
         chk("fill_ready", 16'(tx_ready), (k < 4) ? 16'h1 : 16'h0);
         step();
      end
      tx_valid = 1'b0;
      chk("full_ready", 16'(tx_ready), 16'h0);
      tbr = 1'b1;
      for (int k = 0; k < 4; k++) begin
         next_grant(10, g, d);
         chk("drain_kind", 16'(g), 16'("T"));
         chk("drain_data", 16'(d), 16'(8'hA0 + 8'(k)));
      end
      next_grant(10, g, d);
      chk("fifth_dropped", 16'(g), 16'("-"));
      chk("drain_ready", 16'(tx_ready), 16'h1);

      tbr = 1'b0;
      tx_valid = 1'b1; tx_data = 8'hB0; step();
      tx_data = 8'hB1; step();
      tx_valid = 1'b0;
      rda = 1'b1; spart_byte = 8'hC0; tbr = 1'b1;
      next_grant(10, g, d);
      chk("arb_g1", 16'(g), 16'("R"));
`ifdef SPART_CTRL_RR_ARB_EN
      next_grant(10, g, d);
      chk("arb_g2", 16'(g), 16'("T"));
      chk("arb_g2_data", 16'(d), 16'hB0);
      next_grant(10, g, d);
      chk("arb_g3", 16'(g), 16'("R"));
      rda = 1'b0;
      next_grant(10, g, d);
      chk("arb_tail", 16'(d), 16'hB1);
`else
      next_grant(10, g, d);
      chk("arb_g2", 16'(g), 16'("R"));
      next_grant(10, g, d);
      chk("arb_g3", 16'(g), 16'("R"));
      rda = 1'b0;
      next_grant(10, g, d);
      chk("arb_tail0", 16'(d), 16'hB0);
      next_grant(10, g, d);
      chk("arb_tail1", 16'(d), 16'hB1);
`endif
      chk("arb_tail_kind", 16'(g), 16'("T"));
      next_grant(10, g, d);
      chk("arb_done", 16'(g), 16'("-"));
      chk("arb_rx_data", 16'(rx_data), 16'hC0);

      tx_valid = 1'b1; tx_data = 8'hD0; step();
      tx_valid = 1'b0;
      tx_data = 8'hD1;
      next_grant(10, g, d);
      chk("pre_rst_wr", 16'(g), 16'("T"));
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      next_grant(10, g, d);
      chk("pre_rst_wr2", 16'(g), 16'("T"));
      rst = 1'b1;
      #1;
      chk("midrst_iocs", 16'(iocs), 16'h0);
      chk("midrst_iorw", 16'(iorw), 16'h1);
      chk("midrst_addr", 16'(ioaddr), 16'h1);
      chk("midrst_ready", 16'(tx_ready), 16'h1);
      chk("midrst_done", 16'(cfg_done), 16'h0);
      chk("midrst_rx_valid", 16'(rx_valid), 16'h0);
      chk("midrst_rx_data", 16'(rx_data), 16'h0);
      step();
      rst = 1'b0;
      #1;
      chk("rerun_cfglo", 16'(databus), 16'h8A);
      next_grant(10, g, d);
      chk("fifo_flushed", 16'(g), 16'("-"));
      chk("rerun_done", 16'(cfg_done), 16'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
